// File: rtl/cov_mean_pkg.sv
// Shared types, default widths and helpers for the Cov_Mean statistics engine.
package cov_mean_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int LOG2N_MAX_DEF = 8;
  localparam int SUM_W         = DATA_W_DEF + LOG2N_MAX_DEF;
  localparam int SUMXY_W       = 2 * DATA_W_DEF + LOG2N_MAX_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_MEAN,
    S_COV,
    S_DONE
  } cov_state_e;

  // Requested run lengths beyond what the accumulators are sized for are
  // pinned to the largest supported length.
  function automatic logic [3:0] clamp_log2n(input logic [3:0] v, input int unsigned max_v);
    if (32'(v) > max_v) return 4'(max_v);
    return v;
  endfunction

endpackage

// File: rtl/cov_mean_accum_if.sv
// Sample stream (x, y pairs) with valid/ready flow control.
interface cov_mean_accum_if #(
  parameter int DATA_W = 16
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_x;
  logic signed [DATA_W-1:0] s_y;

  modport master (output s_valid, output s_x, output s_y, input s_ready);
  modport slave  (input s_valid, input s_x, input s_y, output s_ready);
endinterface

// File: rtl/cov_mean_mac.sv
// Product register stage followed by the three running sums.
// A sample accepted at edge k is added to the sums at edge k+1.
module cov_mean_mac
  import cov_mean_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int LOG2N_MAX = LOG2N_MAX_DEF,
  localparam int SW        = DATA_W + LOG2N_MAX,
  localparam int SXW       = 2 * DATA_W + LOG2N_MAX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  output logic signed [SW-1:0]     sum_x,
  output logic signed [SW-1:0]     sum_y,
  output logic signed [SXW-1:0]    sum_xy
);

  logic                       prod_vld;
  logic signed [DATA_W-1:0]   x_q;
  logic signed [DATA_W-1:0]   y_q;
  logic signed [2*DATA_W-1:0] xy_q;

  // Register the accepted sample and its product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_vld <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xy_q     <= '0;
    end else if (clr) begin
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= en;
      if (en) begin
        x_q  <= x;
        y_q  <= y;
        xy_q <= (2*DATA_W)'(x) * (2*DATA_W)'(y);
      end
    end
  end

  // Fold the registered product stage into the sign-extended sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x  <= '0;
      sum_y  <= '0;
      sum_xy <= '0;
    end else if (clr) begin
      sum_x  <= '0;
      sum_y  <= '0;
      sum_xy <= '0;
    end else if (prod_vld) begin
      sum_x  <= sum_x  + {{LOG2N_MAX{x_q[DATA_W-1]}}, x_q};
      sum_y  <= sum_y  + {{LOG2N_MAX{y_q[DATA_W-1]}}, y_q};
      sum_xy <= sum_xy + {{LOG2N_MAX{xy_q[2*DATA_W-1]}}, xy_q};
    end
  end

endmodule

// File: rtl/cov_mean_accum.sv
// Cov_Mean streaming statistics engine: accumulates 2^log2n sample pairs,
// then produces mean_x, mean_y and population covariance by shifting.
// Build option COV_MEAN_ROUND_EN: shifts round half toward +inf instead of
// truncating toward -inf; latency is the same either way.
//
// state | meaning
// IDLE  | waiting for start, results held
// ACCUM | accepting samples, then one drain cycle for the product stage
// MEAN  | register mean_x / mean_y
// COV   | register cov, raise done
// DONE  | one-cycle done state, start may relaunch immediately
module cov_mean_accum
  import cov_mean_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LOG2N_MAX = LOG2N_MAX_DEF
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     start,
  input  logic [3:0]               log2n,
  cov_mean_accum_if.slave          sif,
  output logic                     busy,
  output logic                     done,
  output logic                     res_valid,
  output logic signed [DATA_W-1:0] mean_x,
  output logic signed [DATA_W-1:0] mean_y,
  output logic signed [2*DATA_W:0] cov
);

  localparam int SW  = DATA_W + LOG2N_MAX;
  localparam int SXW = 2 * DATA_W + LOG2N_MAX;
  localparam int CW  = LOG2N_MAX + 1;

  cov_state_e             state;
  logic                   ready_q;
  logic                   drain;
  logic [3:0]             log2n_q;
  logic [3:0]             log2n_c;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          target;
  logic                   accept;
  logic                   hs;

  logic signed [SW-1:0]       sum_x;
  logic signed [SW-1:0]       sum_y;
  logic signed [SXW-1:0]      sum_xy;
  logic signed [SW:0]         half_x;
  logic signed [SXW:0]        half_xy;
  logic signed [2*DATA_W-1:0] mprod;
  logic signed [SXW:0]        prod_ext;

  assign log2n_c     = clamp_log2n(log2n, LOG2N_MAX);
  assign accept      = start && (state == S_IDLE || state == S_DONE);
  assign hs          = sif.s_valid && ready_q;
  assign sif.s_ready = ready_q;

  cov_mean_mac #(
    .DATA_W    (DATA_W),
    .LOG2N_MAX (LOG2N_MAX)
  ) u_mac (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .clr    (accept),
    .en     (hs),
    .x      (sif.s_x),
    .y      (sif.s_y),
    .sum_x  (sum_x),
    .sum_y  (sum_y),
    .sum_xy (sum_xy)
  );

  // Rounding offsets (half an LSB of the shifted result) and the mean product for COV.
  always_comb begin
    half_x  = '0;
    half_xy = '0;
`ifdef COV_MEAN_ROUND_EN
    half_x  = ((SW+1)'(1) << log2n_q) >> 1;
    half_xy = ((SXW+1)'(1) << log2n_q) >> 1;
`endif
    mprod    = (2*DATA_W)'(mean_x) * (2*DATA_W)'(mean_y);
    prod_ext = (SXW+1)'(mprod);
  end

  // Run sequencing, sample counting and registered results.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      drain     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      log2n_q   <= '0;
      cnt       <= '0;
      target    <= '0;
      mean_x    <= '0;
      mean_y    <= '0;
      cov       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_ACCUM;
            ready_q   <= 1'b1;
            drain     <= 1'b0;
            busy      <= 1'b1;
            res_valid <= 1'b0;
            log2n_q   <= log2n_c;
            cnt       <= '0;
            target    <= CW'(1) << log2n_c;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACCUM: begin
          if (hs) begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == target) ready_q <= 1'b0;
          end
          // ready low means all N samples are in; allow one edge for the last add
          if (!ready_q) begin
            if (drain) state <= S_MEAN;
            else       drain <= 1'b1;
          end
        end
        S_MEAN: begin
          mean_x <= DATA_W'(($signed({sum_x[SW-1], sum_x}) + half_x) >>> log2n_q);
          mean_y <= DATA_W'(($signed({sum_y[SW-1], sum_y}) + half_x) >>> log2n_q);
          state  <= S_COV;
        end
        S_COV: begin
          cov       <= (2*DATA_W+1)'((($signed({sum_xy[SXW-1], sum_xy}) + half_xy) >>> log2n_q) - prod_ext);
          done      <= 1'b1;
          res_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cov_mean_accum.sv
// Self-checking bench for cov_mean_accum against an arithmetic reference model.
module tb_cov_mean_accum;

  logic               ACLK = 1'b0;
  logic               ARESETN = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         log2n = 4'd0;
  logic               busy;
  logic               done;
  logic               res_valid;
  logic signed [15:0] mean_x;
  logic signed [15:0] mean_y;
  logic signed [32:0] cov;

  int errors = 0;
  int checks = 0;
  int xs[$];
  int ys[$];

  cov_mean_accum_if #(.DATA_W(16)) sif ();

  cov_mean_accum #(
    .DATA_W    (16),
    .LOG2N_MAX (8)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .start     (start),
    .log2n     (log2n),
    .sif       (sif.slave),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .mean_x    (mean_x),
    .mean_y    (mean_y),
    .cov       (cov)
  );

  always #5 ACLK = ~ACLK;

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: plain sums over the first N samples, floor division by N.
  task automatic model(input logic [3:0] l, output longint mx, output longint my, output longint cv);
    int     le;
    longint d, half, sx, sy, sxy;
    le   = (l > 4'd8) ? 8 : int'(l);
    d    = longint'(1) << le;
    half = 0;
`ifdef COV_MEAN_ROUND_EN
    half = d / 2;
`endif
    sx = 0; sy = 0; sxy = 0;
    for (int i = 0; i < int'(d); i++) begin
      sx  += longint'(xs[i]);
      sy  += longint'(ys[i]);
      sxy += longint'(xs[i]) * longint'(ys[i]);
    end
    mx = floor_div(sx + half, d);
    my = floor_div(sy + half, d);
    cv = floor_div(sxy + half, d) - mx * my;
  endtask

  task automatic fill_const(input int n, input int x, input int y);
    xs.delete(); ys.delete();
    for (int i = 0; i < n; i++) begin xs.push_back(x); ys.push_back(y); end
  endtask

  task automatic fill_ramp();
    xs.delete(); ys.delete();
    for (int i = 1; i <= 4; i++) begin xs.push_back(i); ys.push_back(2 * i); end
  endtask

  task automatic fill_random(input int n);
    logic signed [15:0] r;
    xs.delete(); ys.delete();
    for (int i = 0; i < n; i++) begin
      r = 16'($urandom); xs.push_back(int'(r));
      r = 16'($urandom); ys.push_back(int'(r));
    end
  endtask

  task automatic do_run(input logic [3:0] l, input int gap_pct, input bit poke_start, input bit linger);
    int     le, n, idx, cyc, lat;
    bit     v, hs;
    longint emx, emy, ecv;
    le = (l > 4'd8) ? 8 : int'(l);
    n  = 1 << le;
    model(l, emx, emy, ecv);
    start = 1'b1; log2n = l;
    @(posedge ACLK); #1;
    start = 1'b0;
    checks++;
    if ({sif.s_ready, busy, res_valid} !== 3'b110) begin
      errors++; $display("FAIL start_accept: ready,busy,res_valid=%b want 110", {sif.s_ready, busy, res_valid});
    end
    idx = 0; cyc = 0;
    while (idx < n && cyc < 4000) begin
      v = ($urandom_range(99) >= gap_pct);
      sif.s_valid = v;
      sif.s_x = 16'(xs[idx]);
      sif.s_y = 16'(ys[idx]);
      start = poke_start && (idx == 1);
      hs = v && sif.s_ready;
      @(posedge ACLK); #1;
      if (hs) idx++;
      cyc++;
    end
    sif.s_valid = 1'b0; start = 1'b0;
    checks++;
    if (idx != n) begin errors++; $display("FAIL feed_count: accepted %0d want %0d", idx, n); end
    checks++;
    if ({sif.s_ready, busy} !== 2'b01) begin
      errors++; $display("FAIL ready_drop: ready,busy=%b want 01", {sif.s_ready, busy});
    end
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin @(posedge ACLK); #1; lat++; end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL done_latency: got %0d want 4", lat); end
    checks++;
    if (mean_x !== 16'(emx)) begin errors++; $display("FAIL mean_x: got %0d want %0d", mean_x, emx); end
    checks++;
    if (mean_y !== 16'(emy)) begin errors++; $display("FAIL mean_y: got %0d want %0d", mean_y, emy); end
    checks++;
    if (cov !== 33'(ecv)) begin errors++; $display("FAIL cov: got %0d want %0d", cov, ecv); end
    checks++;
    if ({busy, res_valid} !== 2'b01) begin
      errors++; $display("FAIL done_flags: busy,res_valid=%b want 01", {busy, res_valid});
    end
    if (!linger) begin
      @(posedge ACLK); #1;
      checks++;
      if ({done, res_valid, busy} !== 3'b010 || mean_x !== 16'(emx) || cov !== 33'(ecv)) begin
        errors++; $display("FAIL done_pulse_hold: done,res_valid,busy=%b mean_x=%0d cov=%0d want 010 %0d %0d",
                           {done, res_valid, busy}, mean_x, cov, emx, ecv);
      end
    end
  endtask

  task automatic test_reset();
    sif.s_valid = 1'b0; sif.s_x = '0; sif.s_y = '0;
    ARESETN = 1'b0;
    #2;
    checks++;
    if ({sif.s_ready, busy, done, res_valid} !== 4'b0000 || mean_x !== 16'sd0 || mean_y !== 16'sd0 || cov !== 33'sd0) begin
      errors++; $display("FAIL reset_values: flags=%b mx=%0d my=%0d cov=%0d want all 0",
                         {sif.s_ready, busy, done, res_valid}, mean_x, mean_y, cov);
    end
    @(negedge ACLK); ARESETN = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if ({sif.s_ready, busy, done, res_valid} !== 4'b0000) begin
      errors++; $display("FAIL idle_after_reset: flags=%b want 0000", {sif.s_ready, busy, done, res_valid});
    end
  endtask

  task automatic test_ramp();
    fill_ramp();
    do_run(4'd2, 0, 1'b0, 1'b0);
    checks++;
`ifdef COV_MEAN_ROUND_EN
    if (mean_x !== 16'sd3 || mean_y !== 16'sd5 || cov !== 33'sd0) begin
      errors++; $display("FAIL ramp_values: got %0d %0d %0d want 3 5 0", mean_x, mean_y, cov);
    end
`else
    if (mean_x !== 16'sd2 || mean_y !== 16'sd5 || cov !== 33'sd5) begin
      errors++; $display("FAIL ramp_values: got %0d %0d %0d want 2 5 5", mean_x, mean_y, cov);
    end
`endif
  endtask

  task automatic test_signed();
    fill_const(4, -3, 5);
    do_run(4'd2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    fill_const(1, 7, -2);
    do_run(4'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_full_scale();
    fill_const(256, -32768, -32768);
    do_run(4'd8, 0, 1'b0, 1'b0);
    do_run(4'd12, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps_and_start();
    fill_ramp();
    do_run(4'd2, 40, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    start = 1'b1; log2n = 4'd2;
    @(posedge ACLK); #1;
    start = 1'b0;
    sif.s_valid = 1'b1; sif.s_x = 16'sd1; sif.s_y = 16'sd2;
    @(posedge ACLK); #1;
    sif.s_x = 16'sd2; sif.s_y = 16'sd4;
    @(posedge ACLK); #1;
    sif.s_valid = 1'b0;
    ARESETN = 1'b0;
    #2;
    checks++;
    if ({sif.s_ready, busy, done, res_valid} !== 4'b0000 || mean_x !== 16'sd0 || mean_y !== 16'sd0 || cov !== 33'sd0) begin
      errors++; $display("FAIL midrun_reset: flags=%b mx=%0d my=%0d cov=%0d want all 0",
                         {sif.s_ready, busy, done, res_valid}, mean_x, mean_y, cov);
    end
    @(negedge ACLK); ARESETN = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if ({sif.s_ready, busy} !== 2'b00) begin
      errors++; $display("FAIL idle_after_midrun_reset: ready,busy=%b want 00", {sif.s_ready, busy});
    end
    fill_ramp();
    do_run(4'd2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] l;
    for (int k = 0; k < 6; k++) begin
      l = 4'($urandom_range(5, 0));
      fill_random(1 << l);
      do_run(l, 30, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    fill_random(8);
    do_run(4'd3, 0, 1'b0, 1'b1);
    fill_random(4);
    do_run(4'd2, 20, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_signed();
    test_single();
    test_full_scale();
    test_gaps_and_start();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
